aes_arbiter: RTL and testbench

AES_ARBITER -- requirements
Module: aes_arbiter

---
 rtl/aes_arbiter_if.sv | 32 +++
 rtl/aes_arbiter.sv | 135 +++++++++++++
 tb/tb_aes_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_arbiter_if.sv
// Bus bundle between the two decrypt requesters, the arbiter and the shared AES core.
// master: arbiter view (drives gnt/done/err/msg_de*, aes_start/aes_key/aes_msg_en).
// slave : environment view (drives req, operands, aes_done/aes_msg_de).
interface aes_arbiter_if;
  localparam int unsigned DATA_W = 128;

  logic [1:0]        req;
  logic [DATA_W-1:0] msg_en0;
  logic [DATA_W-1:0] msg_en1;
  logic [DATA_W-1:0] key0;
  logic [DATA_W-1:0] key1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              err;
  logic [DATA_W-1:0] msg_de0;
  logic [DATA_W-1:0] msg_de1;
  logic              aes_start;
  logic [DATA_W-1:0] aes_key;
  logic [DATA_W-1:0] aes_msg_en;
  logic              aes_done;
  logic [DATA_W-1:0] aes_msg_de;

  modport master (
    input  req, msg_en0, msg_en1, key0, key1, aes_done, aes_msg_de,
    output gnt, done, err, msg_de0, msg_de1, aes_start, aes_key, aes_msg_en
  );

  modport slave (
    output req, msg_en0, msg_en1, key0, key1, aes_done, aes_msg_de,
    input  gnt, done, err, msg_de0, msg_de1, aes_start, aes_key, aes_msg_en
  );
endinterface

// File: rtl/aes_arbiter.sv
// Two-channel round-robin arbiter in front of one shared AES decrypt core.
// Ports: clk, reset_n (synchronous, active-low), bus (aes_arbiter_if.master).
// The owner's key/ciphertext are latched at grant, the core is started with a
// one-cycle pulse, and the result (or a timeout abort) is returned on done/err.
module aes_arbiter #(
  parameter int unsigned      LAT_W   = 16,
  parameter logic [LAT_W-1:0] TIMEOUT = 16'd65535
) (
  input  logic           clk,
  input  logic           reset_n,
  aes_arbiter_if.master  bus
);
  localparam int unsigned      DATA_W  = 128;
  localparam logic [LAT_W-1:0] TO_LAST = TIMEOUT - LAT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic              r_owner, w_owner_next;
  logic              r_last, w_last_next;
  logic [LAT_W-1:0]  r_cnt, w_cnt_next;
  logic [1:0]        r_gnt, w_gnt_next;
  logic [1:0]        r_done, w_done_next;
  logic              r_err, w_err_next;
  logic              r_start, w_start_next;
  logic [DATA_W-1:0] r_key, w_key_next;
  logic [DATA_W-1:0] r_msg, w_msg_next;
  logic [DATA_W-1:0] r_de0, w_de0_next;
  logic [DATA_W-1:0] r_de1, w_de1_next;
  logic              w_pick;

  // Contention goes to the channel not served last; a lone request always wins.
  assign w_pick = (bus.req == 2'b11) ? ~r_last : bus.req[1];

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state and next register values
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    w_gnt_next   = r_gnt;
    w_done_next  = r_done;
    w_err_next   = r_err;
    w_start_next = 1'b0;
    w_key_next   = r_key;
    w_msg_next   = r_msg;
    w_de0_next   = r_de0;
    w_de1_next   = r_de1;
    case (r_state)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          w_owner_next = w_pick;
          w_gnt_next   = w_pick ? 2'b10 : 2'b01;
          w_key_next   = w_pick ? bus.key1 : bus.key0;
          w_msg_next   = w_pick ? bus.msg_en1 : bus.msg_en0;
          w_start_next = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_cnt_next   = '0;
        w_state_next = S_BUSY;
      end
      S_BUSY: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (bus.aes_done) begin
          if (r_owner) w_de1_next = bus.aes_msg_de;
          else         w_de0_next = bus.aes_msg_de;
          w_err_next   = 1'b0;
          w_done_next  = r_gnt;
          w_state_next = S_DONE;
        end else if (r_cnt == TO_LAST) begin
          w_err_next   = 1'b1;
          w_done_next  = r_gnt;
          w_state_next = S_DONE;
        end else if (r_cnt != TIMEOUT) begin
          w_cnt_next = r_cnt + LAT_W'(1);
        end
      end
      S_DONE: begin
        if (!bus.req[r_owner]) begin
          w_gnt_next   = 2'b00;
          w_done_next  = 2'b00;
          w_last_next  = r_owner;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_key   <= '0;
      r_msg   <= '0;
      r_de0   <= '0;
      r_de1   <= '0;
    end else begin
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
      r_gnt   <= w_gnt_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      r_start <= w_start_next;
      r_key   <= w_key_next;
      r_msg   <= w_msg_next;
      r_de0   <= w_de0_next;
      r_de1   <= w_de1_next;
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.aes_start  = r_start;
  assign bus.aes_key    = r_key;
  assign bus.aes_msg_en = r_msg;
  assign bus.msg_de0    = r_de0;
  assign bus.msg_de1    = r_de1;
endmodule

// File: tb/tb_aes_arbiter.sv
// Self-checking bench for aes_arbiter: directed vectors, a table of grant
// scenarios and a randomized run, all checked against a transaction-level model.
module tb_aes_arbiter;
  localparam int T = 16;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic reset_n;
  aes_arbiter_if bus();

  aes_arbiter #(.LAT_W(16), .TIMEOUT(16'd16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0, cyc = 0;
  int n_starts = 0, n_gnt11 = 0;
  int core_lat = 12;
  bit lat_rand = 0, rand_en = 0;
  int stray_mode = 0;

  // Reference model state
  bit           m_active = 0, m_done_ph = 0, m_err = 0;
  logic         m_owner = 1'b0, m_last = 1'b1;
  int           m_s = -100, m_L = 0, m_dcyc = -100;
  logic [127:0] m_key, m_msg, m_de0 = '0, m_de1 = '0;

  typedef struct {
    logic [1:0] req;
    int         lat;
    logic [1:0] gnt;
    logic       err;
    int         dly;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural core: the known-answer vector, otherwise an arbitrary mixing function.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] c);
    if (k == KAT_KEY && c == KAT_CT) return KAT_PT;
    return k ^ {c[63:0], c[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
  endtask

  // One clock: advance model by the inputs of the cycle just ended, compare, then drive.
  task automatic tick();
    logic [1:0]   p_req, oh, r;
    logic         p_rst;
    logic [127:0] p_k0, p_k1, p_m0, p_m1;
    p_req = bus.req; p_rst = reset_n;
    p_k0 = bus.key0; p_k1 = bus.key1; p_m0 = bus.msg_en0; p_m1 = bus.msg_en1;
    @(posedge clk); #1; cyc++;
    if (!p_rst) begin
      m_active = 0; m_done_ph = 0; m_last = 1'b1; m_de0 = '0; m_de1 = '0;
    end else if (!m_active) begin
      if (p_req != 2'b00) begin
        m_owner = (p_req == 2'b11) ? ~m_last : p_req[1];
        m_active = 1; m_done_ph = 0; m_s = cyc;
        m_key = m_owner ? p_k1 : p_k0;
        m_msg = m_owner ? p_m1 : p_m0;
        if (lat_rand) m_L = $urandom_range(1, 20);
        else          m_L = (core_lat == 0) ? 1000 : core_lat;
        m_err  = (m_L > T);
        m_dcyc = cyc + ((m_L > T) ? T : m_L) + 1;
      end
    end else if (!m_done_ph) begin
      if (cyc == m_dcyc) begin
        m_done_ph = 1;
        if (!m_err) begin
          if (m_owner) m_de1 = core_fn(m_key, m_msg);
          else         m_de0 = core_fn(m_key, m_msg);
        end
      end
    end else if (!p_req[m_owner]) begin
      m_active = 0; m_done_ph = 0; m_last = m_owner;
    end
    oh = m_owner ? 2'b10 : 2'b01;
    chk("gnt", bus.gnt, m_active ? oh : 2'b00);
    chk("aes_start", bus.aes_start, m_active && cyc == m_s);
    chk("done", bus.done, m_done_ph ? oh : 2'b00);
    if (m_done_ph) chk("err", bus.err, m_err);
    chk("msg_de0", bus.msg_de0, m_de0);
    chk("msg_de1", bus.msg_de1, m_de1);
    if (m_active && cyc == m_s) begin
      chk("aes_key", bus.aes_key, m_key);
      chk("aes_msg_en", bus.aes_msg_en, m_msg);
    end
    if (bus.aes_start) n_starts++;
    if (bus.gnt == 2'b11) n_gnt11++;
    // Core behaviour for the coming cycle
    bus.aes_done = 1'b0;
    bus.aes_msg_de = rnd128();
    if (m_active && !m_done_ph && cyc != m_s) begin
      if (cyc == m_s + m_L) begin
        bus.aes_done = 1'b1;
        bus.aes_msg_de = core_fn(m_key, m_msg);
      end
    end else if (stray_mode == 2 || (stray_mode == 1 && $urandom_range(0, 3) == 0)) begin
      bus.aes_done = 1'b1;
    end
    // Randomized requesters and operands that keep changing after grant
    if (rand_en) begin
      r = bus.req;
      for (int c = 0; c < 2; c++) begin
        if (!r[c])             begin if ($urandom_range(0, 2) == 0)  r[c] = 1'b1; end
        else if (bus.done[c])  begin if ($urandom_range(0, 1) == 0)  r[c] = 1'b0; end
        else if ($urandom_range(0, 15) == 0) r[c] = 1'b0;
      end
      bus.req = r;
      bus.key0 = rnd128(); bus.key1 = rnd128();
      bus.msg_en0 = rnd128(); bus.msg_en1 = rnd128();
    end
  endtask

  // Wait for aes_start (want_done=0) or any done bit (want_done=1), bounded.
  task automatic wait_sig(input bit want_done, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (want_done ? (bus.done != 2'b00) : (bus.aes_start == 1'b1)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_total++;
      $display("FAIL wait_%s cyc=%0d got=none want=event", want_done ? "done" : "start", cyc);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; bus.req = 2'b00;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic drop_req();
    bus.req = 2'b00;
    tick(); tick();
  endtask

  initial begin
    int st, dn;
    tbl[0] = '{2'b11,  3, 2'b01, 1'b0,  4};
    tbl[1] = '{2'b11,  4, 2'b10, 1'b0,  5};
    tbl[2] = '{2'b10,  2, 2'b10, 1'b0,  3};
    tbl[3] = '{2'b11,  5, 2'b01, 1'b0,  6};
    tbl[4] = '{2'b01,  1, 2'b01, 1'b0,  2};
    tbl[5] = '{2'b11, 16, 2'b10, 1'b0, 17};
    tbl[6] = '{2'b01,  0, 2'b01, 1'b1, 17};
    tbl[7] = '{2'b11,  7, 2'b10, 1'b0,  8};

    reset_n = 1'b0;
    bus.req = 2'b00; bus.aes_done = 1'b0; bus.aes_msg_de = '0;
    bus.key0 = '0; bus.key1 = '0; bus.msg_en0 = '0; bus.msg_en1 = '0;
    do_reset();

    // Reset state
    chk("rst_err", bus.err, 1'b0);
    chk("rst_aes_key", bus.aes_key, '0);
    chk("rst_aes_msg_en", bus.aes_msg_en, '0);

    // Known-answer decrypt on channel 0, 12-cycle core
    bus.key0 = KAT_KEY; bus.msg_en0 = KAT_CT; core_lat = 12; n_starts = 0;
    bus.req = 2'b01;
    wait_sig(0, 10, st);
    wait_sig(1, 40, dn);
    chk("kat_msg_de0", bus.msg_de0, KAT_PT);
    chk("kat_done", bus.done, 2'b01);
    chk("kat_err", bus.err, 1'b0);
    chk("kat_lat", dn - st, 13);
    chk("kat_starts", n_starts, 1);
    drop_req();

    // Core never answers: timeout abort, result untouched
    core_lat = 0; bus.key0 = rnd128(); bus.req = 2'b01;
    wait_sig(0, 10, st);
    wait_sig(1, 40, dn);
    chk("to_done", bus.done, 2'b01);
    chk("to_err", bus.err, 1'b1);
    chk("to_lat", dn - st, 17);
    chk("to_msg_de0", bus.msg_de0, KAT_PT);
    drop_req();

    // aes_done coincident with the last timeout cycle
    core_lat = 16; bus.key0 = rnd128(); bus.msg_en0 = rnd128(); bus.req = 2'b01;
    wait_sig(0, 10, st);
    wait_sig(1, 40, dn);
    chk("edge_err", bus.err, 1'b0);
    chk("edge_lat", dn - st, 17);
    chk("edge_msg_de0", bus.msg_de0, core_fn(bus.key0, bus.msg_en0));
    drop_req();

    // Channel 1 drops its request mid-operation
    core_lat = 6; bus.key1 = rnd128(); bus.msg_en1 = rnd128(); bus.req = 2'b10;
    wait_sig(0, 10, st);
    tick(); tick();
    bus.req = 2'b00;
    wait_sig(1, 40, dn);
    chk("drop_done", bus.done, 2'b10);
    tick();
    chk("drop_done_after", bus.done, 2'b00);
    chk("drop_gnt_after", bus.gnt, 2'b00);

    // Both channels requesting from reset
    do_reset();
    n_starts = 0; n_gnt11 = 0; core_lat = 4; bus.req = 2'b11;
    wait_sig(0, 10, st);
    chk("rr_first_gnt", bus.gnt, 2'b01);
    wait_sig(1, 40, dn);
    chk("rr_first_done", bus.done, 2'b01);
    bus.req = 2'b10;
    wait_sig(0, 10, st);
    chk("rr_second_gnt", bus.gnt, 2'b10);
    wait_sig(1, 40, dn);
    chk("rr_second_done", bus.done, 2'b10);
    drop_req();
    chk("rr_starts", n_starts, 2);
    chk("rr_gnt11", n_gnt11, 0);

    // Grant-order table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.key0 = rnd128(); bus.key1 = rnd128();
      bus.msg_en0 = rnd128(); bus.msg_en1 = rnd128();
      bus.req = tbl[i].req; core_lat = tbl[i].lat;
      wait_sig(0, 10, st);
      if (st >= 0) chk($sformatf("tbl%0d_gnt", i), bus.gnt, tbl[i].gnt);
      wait_sig(1, 40, dn);
      if (dn >= 0) begin
        chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].gnt);
        chk($sformatf("tbl%0d_err", i), bus.err, tbl[i].err);
        chk($sformatf("tbl%0d_lat", i), dn - st, tbl[i].dly);
      end
      drop_req();
    end

    // Reset during BUSY, followed by stray core completions
    core_lat = 0; bus.req = 2'b01;
    wait_sig(0, 10, st);
    repeat (4) tick();
    reset_n = 1'b0; bus.req = 2'b00;
    tick();
    reset_n = 1'b1; stray_mode = 2;
    repeat (5) tick();
    stray_mode = 0;
    chk("mrst_gnt", bus.gnt, 2'b00);
    chk("mrst_done", bus.done, 2'b00);
    chk("mrst_err", bus.err, 1'b0);
    chk("mrst_start", bus.aes_start, 1'b0);
    chk("mrst_msg_de0", bus.msg_de0, '0);
    chk("mrst_msg_de1", bus.msg_de1, '0);
    chk("mrst_aes_key", bus.aes_key, '0);

    // Randomized traffic against the model
    lat_rand = 1; stray_mode = 1; rand_en = 1;
    repeat (3000) tick();
    rand_en = 0; stray_mode = 0;
    bus.req = 2'b00;
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
